// File: rtl/bcd_convert_arbiter_if.sv
// Requester-side bus of the shared BCD converter: level requests and packed
// binary values in, one-hot acknowledge and the registered BCD result out.
interface bcd_convert_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int BIN_W   = 6
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*BIN_W-1:0] bin_in;
    logic [NUM_REQ-1:0]       ack;
    logic [11:0]              bcd_out;
    logic [ID_W-1:0]          bcd_id;
    logic                     bcd_valid;
    logic                     busy;

    modport master (
        output req, bin_in,
        input  ack, bcd_out, bcd_id, bcd_valid, busy
    );

    modport slave (
        input  req, bin_in,
        output ack, bcd_out, bcd_id, bcd_valid, busy
    );
endinterface

// File: rtl/bcd_convert_arbiter.sv
// Round-robin shared binary-to-BCD converter: grants one requester at a time
// and runs a one-bit-per-cycle double-dabble into a 3-digit packed result.
module bcd_convert_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int BIN_W   = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    bcd_convert_arbiter_if.slave  bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state, state_next;
    logic [ID_W-1:0]    rr_ptr, rr_next;
    logic [ID_W-1:0]    grant, grant_next;
    logic [BIN_W-1:0]   shreg, shreg_next;
    logic [11:0]        acc, acc_next, acc_adj;
    logic [CNT_W-1:0]   count, count_next;
    logic [11:0]        bcd_out, bcd_out_next;
    logic [ID_W-1:0]    bcd_id, bcd_id_next;
    logic               mask_en;
    logic [NUM_REQ-1:0] eligible;
    logic               found;
    logic [ID_W-1:0]    pick;
    int                 idx;

    // The requester acked in the previous cycle sits out exactly one arbitration.
    always_comb begin
        eligible = bus.req;
        if (mask_en) begin
            eligible[grant] = 1'b0;
        end
    end

    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!found && eligible[ID_W'(idx)]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end
    end

    always_comb begin
        acc_adj = acc;
        for (int n = 0; n < 3; n++) begin
            if (acc[n*4 +: 4] >= 4'd5) begin
                acc_adj[n*4 +: 4] = acc[n*4 +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_next   = state;
        rr_next      = rr_ptr;
        grant_next   = grant;
        shreg_next   = shreg;
        acc_next     = acc;
        count_next   = count;
        bcd_out_next = bcd_out;
        bcd_id_next  = bcd_id;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_next = pick;
                    shreg_next = bus.bin_in[pick*BIN_W +: BIN_W];
                    acc_next   = '0;
                    count_next = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                acc_next   = 12'({acc_adj, shreg[BIN_W-1]});
                shreg_next = shreg << 1;
                count_next = count + CNT_W'(1);
                // Result is loaded on the last shift so it is visible during DONE.
                if (count == CNT_W'(BIN_W - 1)) begin
                    state_next   = DONE;
                    bcd_out_next = acc_next;
                    bcd_id_next  = grant;
                end
            end
            DONE: begin
                state_next = IDLE;
                rr_next    = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            grant   <= '0;
            shreg   <= '0;
            acc     <= '0;
            count   <= '0;
            bcd_out <= '0;
            bcd_id  <= '0;
            mask_en <= 1'b0;
        end else begin
            state   <= state_next;
            rr_ptr  <= rr_next;
            grant   <= grant_next;
            shreg   <= shreg_next;
            acc     <= acc_next;
            count   <= count_next;
            bcd_out <= bcd_out_next;
            bcd_id  <= bcd_id_next;
            mask_en <= (state == DONE);
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.bcd_valid = (state == DONE);
    assign bus.ack       = (state == DONE) ? (NUM_REQ'(1) << grant) : '0;
    assign bus.bcd_out   = bcd_out;
    assign bus.bcd_id    = bcd_id;
endmodule
